// File: rtl/poly_wave_synth_if.sv
// Sample stream between poly_wave_synth (master) and the audio codec (slave).
//
// Handshake: the master raises sample_valid with a stable sample word and
// keeps both unchanged until a cycle in which sample_ready is 1; that clock
// edge is the transfer, and sample_valid drops in the following cycle.
// sample_ready may be asserted at any time and carries no meaning while
// sample_valid is low.
interface poly_wave_synth_if;
    logic [23:0] sample;
    logic        sample_valid;
    logic        sample_ready;

    modport master (output sample, output sample_valid, input sample_ready);
    modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/poly_wave_synth.sv
// Polyphonic, time-multiplexed tone generator.
// One phase accumulator per voice, all voices scanned once per audio sample
// and summed into a left-aligned 24-bit unsigned word.
// Build option: define POLY_SYNTH_TRI_EN to build the triangle waveform;
// without it wave_sel 2'b10 produces a square wave.
module poly_wave_synth #(
    parameter int NUM_VOICES = 16,
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 8,
    parameter int SAMPLE_DIV = 1042
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_VOICES-1:0] key_mask,
    input  logic [2:0]            octave,
    input  logic [1:0]            wave_sel,
    poly_wave_synth_if.master     out_if,
    output logic                  overrun,
    output logic [1:0]            dbg_state
);
    localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int SUM_W = OUT_W + $clog2(NUM_VOICES);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int SMP_W = 24;

    typedef enum logic [1:0] {IDLE, SCAN, MIX, VALID} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [VW-1:0]     voice;
    logic [ACC_W-1:0]  phase [NUM_VOICES];
    logic [SUM_W-1:0]  mix_acc;
    logic [SMP_W-1:0]  sample_q;
    logic              sample_valid_q;

    // Per-voice datapath for the voice currently being scanned
    logic [3:0]        note;
    logic [3:0]        oct_sum;
    logic [2:0]        shift;
    logic [13:0]       base;
    logic [20:0]       inc_wide;
    logic [ACC_W-1:0]  cur_phase;
    logic [ACC_W-1:0]  cur_inc;
    logic [OUT_W:0]    p;
    logic [OUT_W-1:0]  p_lo;
    logic [OUT_W-1:0]  amp;

    // Phase increments for C..B at the lowest octave (24-bit accumulator, 48 kHz)
    function automatic logic [13:0] base_of(input logic [3:0] n);
        case (n)
            4'd0:    return 14'd5715;
            4'd1:    return 14'd6055;
            4'd2:    return 14'd6415;
            4'd3:    return 14'd6797;
            4'd4:    return 14'd7201;
            4'd5:    return 14'd7629;
            4'd6:    return 14'd8083;
            4'd7:    return 14'd8563;
            4'd8:    return 14'd9072;
            4'd9:    return 14'd9612;
            4'd10:   return 14'd10183;
            4'd11:   return 14'd10789;
            default: return 14'd0;
        endcase
    endfunction

    assign tick      = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign note      = 4'(int'(voice) % 12);
    // Voices above the first twelve continue into the next octave; the
    // shift saturates so the top octave repeats rather than overflowing.
    assign oct_sum   = {1'b0, octave} + 4'(int'(voice) / 12);
    assign shift     = (oct_sum > 4'd7) ? 3'd7 : oct_sum[2:0];
    assign base      = base_of(note);
    assign inc_wide  = {7'b0, base} << shift;
    assign cur_inc   = ACC_W'(inc_wide);
    assign cur_phase = phase[voice];
    assign p         = cur_phase[ACC_W-1 -: OUT_W+1];
    assign p_lo      = p[OUT_W-1:0];

    // Waveform amplitude of the scanned voice; released keys contribute nothing
    always_comb begin
        amp = '0;
        if (key_mask[voice]) begin
            case (wave_sel)
                2'b00:   amp = p[OUT_W] ? '0 : '1;
                2'b01:   amp = {OUT_W{1'b1}} - p_lo;
`ifdef POLY_SYNTH_TRI_EN
                2'b10:   amp = p[OUT_W] ? ~p_lo : p_lo;
`else
                2'b10:   amp = p[OUT_W] ? '0 : '1;
`endif
                default: amp = '0;
            endcase
        end
    end

    // Sample-rate divider, free running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Scan/mix/handshake FSM with the phase accumulators and mix sum
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            voice          <= '0;
            mix_acc        <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            overrun        <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state   <= SCAN;
                        voice   <= '0;
                        mix_acc <= '0;
                    end
                end
                SCAN: begin
                    mix_acc <= mix_acc + SUM_W'(amp);
                    // A released key parks its phase at 0 so the next press starts clean
                    phase[voice] <= key_mask[voice] ? (cur_phase + cur_inc) : '0;
                    if (voice == VW'(NUM_VOICES - 1)) begin
                        state <= MIX;
                    end else begin
                        voice <= voice + VW'(1);
                    end
                end
                MIX: begin
                    sample_q       <= SMP_W'(mix_acc) << (SMP_W - SUM_W);
                    sample_valid_q <= 1'b1;
                    state          <= VALID;
                end
                VALID: begin
                    if (out_if.sample_ready) begin
                        sample_valid_q <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A tick that finds the engine busy is lost; remember that it happened
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    assign out_if.sample       = sample_q;
    assign out_if.sample_valid = sample_valid_q;
    assign dbg_state           = state;
endmodule
